control_sequencer: RTL and testbench

Hardwired control unit that sits directly upstream of the `Datapath` block and drives its `enable`, `busSelect`, `MR_Read` and `Control_Signals` inputs. It steps a six-state fetch/execute sequence (T0–T5) for three-register ALU instructions. It takes `IR` contents from the datapath, produces the per-cycle strobes that the Phase 1 testbenches currently hand-drive, and waits on a memory-ready handshake during instruction fetch.

---
 rtl/control_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0-T5 fetch/execute sequencer for three-register ALU instructions.
// Build macro SEQ_SINGLE_STEP_EN (optional) gates every state transition on the step input.
module control_sequencer #(
    parameter bit IDLE_ON_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        step,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        MR_Read,
    output logic        inc_pc,
    output logic [3:0]  Control_Signals,
    output logic        busy,
    output logic        illegal,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic       advance;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic [3:0] alu_op;
    logic       legal;
    logic       unary_op;

    logic [3:0] alu_op_q, alu_op_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] src2_q, src2_d;

    // Zero means "no mapping", i.e. an illegal opcode.
    function automatic logic [3:0] map_op(input logic [4:0] opc);
        case (opc)
            5'b00000: return 4'd1;
            5'b00001: return 4'd2;
            5'b00010: return 4'd3;
            5'b00011: return 4'd4;
            5'b00100: return 4'd5;
            5'b00101: return 4'd6;
            5'b00110: return 4'd7;
            5'b00111: return 4'd8;
            5'b01000: return 4'd9;
            5'b01001: return 4'd10;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] reg_sel(input logic [3:0] r);
        return 32'h1 << r;
    endfunction

    assign opcode   = ir[31:27];
    assign ra       = ir[26:23];
    assign rb       = ir[22:19];
    assign rc       = ir[18:15];
    assign alu_op   = map_op(opcode);
    assign legal    = (alu_op != 4'd0);
    assign unary_op = (opcode == 5'b01000) || (opcode == 5'b01001);

    logic unused_ir;
    assign unused_ir = ^ir[14:0];

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
    logic unused_step;
    assign unused_step = step;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            alu_op_q <= 4'd0;
            ra_q     <= 4'd0;
            src2_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            ra_q     <= ra_d;
            src2_q   <= src2_d;
        end
    end

    // Decoded fields are captured when T3 completes so T4/T5 do not depend on ir afterwards.
    always_comb begin
        alu_op_d = alu_op_q;
        ra_d     = ra_q;
        src2_d   = src2_q;
        if (state_q == S_T3 && advance) begin
            alu_op_d = alu_op;
            ra_d     = ra;
            src2_d   = unary_op ? rb : rc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_rdy) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = legal ? S_T4 : S_HALT;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = run ? S_T0 : S_IDLE;
            S_HALT: state_d = IDLE_ON_HALT ? S_IDLE : S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (!advance) begin
            state_d = state_q;
        end
    end

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        MR_Read         = 1'b0;
        inc_pc          = 1'b0;
        Control_Signals = 4'd0;
        busy            = 1'b1;
        illegal         = 1'b0;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_T0: begin
                busSelect[20] = 1'b1;
                enable[25]    = 1'b1;
                enable[24]    = 1'b1;
                inc_pc        = 1'b1;
            end
            S_T1: begin
                busSelect[19] = 1'b1;
                enable[20]    = 1'b1;
                enable[21]    = 1'b1;
                MR_Read       = 1'b1;
            end
            S_T2: begin
                busSelect[21] = 1'b1;
                enable[23]    = 1'b1;
            end
            S_T3: begin
                if (legal) begin
                    busSelect  = reg_sel(rb);
                    enable[27] = 1'b1;
                end
            end
            S_T4: begin
                busSelect       = reg_sel(src2_q);
                enable[24]      = 1'b1;
                Control_Signals = alu_op_q;
            end
            S_T5: begin
                busSelect[19] = 1'b1;
                enable        = reg_sel(ra_q);
            end
            S_HALT: begin
                busy    = 1'b0;
                illegal = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream checked cycle-by-cycle against an
// instruction-level expectation model (expected output vector per cycle in exp_q).
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic        step;
    logic        mem_rdy;
    logic [31:0] ir;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic        MR_Read;
    logic        inc_pc;
    logic [3:0]  Control_Signals;
    logic        busy;
    logic        illegal;
    logic [2:0]  dbg_state;

    logic [71:0] obs;
    logic [71:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          need_idle;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    control_sequencer #(.IDLE_ON_HALT(1'b1)) dut (
        .clk             (clk),
        .clr             (clr),
        .run             (run),
        .step            (step),
        .mem_rdy         (mem_rdy),
        .ir              (ir),
        .enable          (enable),
        .busSelect       (busSelect),
        .MR_Read         (MR_Read),
        .inc_pc          (inc_pc),
        .Control_Signals (Control_Signals),
        .busy            (busy),
        .illegal         (illegal),
        .dbg_state       (dbg_state)
    );

    assign obs = {enable, busSelect, MR_Read, inc_pc, Control_Signals, busy, illegal};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] expv);
        n_checks++;
        if (got !== expv)
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        else
            n_pass++;
    endtask

    function automatic logic [71:0] vec(input logic [31:0] e, input logic [31:0] b,
                                        input logic mr, input logic inc,
                                        input logic [3:0] cs, input logic bsy,
                                        input logic ill);
        return {e, b, mr, inc, cs, bsy, ill};
    endfunction

    function automatic logic [31:0] bit_at(input int idx);
        return 32'h1 << idx;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- reference model ----------------
    // Expected output of every cycle of one instruction, given the number of fetch wait states.
    task automatic model_instr(input logic [31:0] iv, input int waits);
        int op = int'(iv[31:27]);
        int ra = int'(iv[26:23]);
        int rb = int'(iv[22:19]);
        int rc = int'(iv[18:15]);
        bit ok = (op <= 9);
        int src2 = (op == 8 || op == 9) ? rb : rc;
        exp_q.push_back(vec(bit_at(25) | bit_at(24), bit_at(20), 1'b0, 1'b1, 4'd0, 1'b1, 1'b0));
        for (int k = 0; k <= waits; k++)
            exp_q.push_back(vec(bit_at(20) | bit_at(21), bit_at(19), 1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
        exp_q.push_back(vec(bit_at(23), bit_at(21), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
        if (ok) begin
            exp_q.push_back(vec(bit_at(27), bit_at(rb), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
            exp_q.push_back(vec(bit_at(24), bit_at(src2), 1'b0, 1'b0, 4'(op + 1), 1'b1, 1'b0));
            exp_q.push_back(vec(bit_at(ra), bit_at(19), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(vec(32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
            exp_q.push_back(vec(32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
        end
    endtask

    // ---------------- driver ----------------
    // Check the state entered at this edge, then set inputs sampled at the next edge.
    task automatic do_cycle(input string tag, input logic rdy, input logic runv);
        logic [71:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, obs, e);
        mem_rdy = rdy;
        run     = runv;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check({tag, "_hold"}, obs, e);
        end
        step = 1'b1;
`else
        step = rbit();
`endif
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(72'h0);
            do_cycle("IDLE", rbit(), (i == n - 1) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic exec_instr(input logic [31:0] iv, input int waits,
                              input bit run_after, input bit abort);
        bit ok = (iv[31:27] <= 5'd9);
        ir = iv;
        model_instr(iv, waits);
        do_cycle("T0", rbit(), rbit());
        for (int k = 0; k <= waits; k++)
            do_cycle("T1", (k == waits) ? 1'b1 : 1'b0, rbit());
        do_cycle("T2", rbit(), rbit());
        do_cycle("T3", rbit(), rbit());
        if (!ok) begin
            do_cycle("HALT", rbit(), 1'b0);
            need_idle = 1'b1;
        end else if (abort) begin
            do_cycle("T4", rbit(), 1'b0);
            #2 clr = 1'b1;
            #1 check("abort_clr", obs, 72'h0);
            exp_q.delete();
            #2 clr = 1'b0;
            need_idle = 1'b1;
        end else begin
            do_cycle("T4", rbit(), rbit());
            do_cycle("T5", rbit(), run_after);
            need_idle = !run_after;
        end
    endtask

    function automatic logic [31:0] mk_instr(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom_range(0, 32767))};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        clr     = 1'b0;
        run     = 1'b0;
        step    = 1'b1;
        mem_rdy = 1'b0;
        ir      = 32'h0;
        #1 clr = 1'b1;
        #1 check("reset_outputs", obs, 72'h0);
        #10 clr = 1'b0;

        idle_cycles(2);
        exec_instr(32'h08A28000, 0, 1'b0, 1'b0);           // SUB R1,R4,R5
        if (need_idle) idle_cycles(2);
        exec_instr(32'h08A28000, 3, 1'b0, 1'b0);           // fetch with three wait states
        if (need_idle) idle_cycles(1);
        exec_instr(32'hF8000000, 0, 1'b1, 1'b0);           // illegal opcode
        if (need_idle) idle_cycles(1);
        exec_instr(mk_instr(0, 2, 2, 2), 1, 1'b1, 1'b0);   // ADD R2,R2,R2 back-to-back
        exec_instr(mk_instr(8, 7, 3, 12), 0, 1'b1, 1'b0);  // NEG uses Rb in T4
        exec_instr(mk_instr(9, 15, 0, 6), 2, 1'b1, 1'b1);  // NOT, reset during T4
        if (need_idle) idle_cycles(2);

        for (int n = 0; n < 60; n++) begin
            int op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 31))
                                                 : int'($urandom_range(0, 9));
            exec_instr(mk_instr(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                int'($urandom_range(0, 15))),
                       int'($urandom_range(0, 3)), rbit(), ($urandom_range(0, 9) == 0));
            if (need_idle) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
